logic_axi4_stream_timer_scheduler: RTL and testbench

- Shares one AXI4-Stream timer instance between REQUESTERS independent clients.
- Each client requests a one-shot delay. The block arbitrates round-robin, programs the timer with the granted period over an AXI4-Stream config channel, waits for the timer's expiry beat, then pulses done to the owner.
- Sits between client logic and the timer's rx/tx stream ports; the timer is instantiated alongside it.

---
 rtl/logic_axi4_stream_timer_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_logic_axi4_stream_timer_scheduler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_axi4_stream_timer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : logic_axi4_stream_timer_scheduler
// Purpose  : Round-robin scheduler that shares one AXI4-Stream timer between
//            REQUESTERS clients. The scheduler programs the timer with a
//            one-shot period and pulses done to the client that owns it.
// Option   : LOGIC_AXI4_STREAM_TIMER_SCHEDULER_WATCHDOG_EN adds a watchdog
//            that ends WAIT early and raises timeout.
// Revision : 1.0 - initial release
// ============================================================================
module logic_axi4_stream_timer_scheduler #(
  parameter int REQUESTERS    = 4,
  parameter int COUNTER_WIDTH = 16,
  parameter int TDATA_BYTES   = 4
`ifdef LOGIC_AXI4_STREAM_TIMER_SCHEDULER_WATCHDOG_EN
  ,
  parameter int WATCHDOG_MARGIN = 16
`endif
) (
  input  logic                                                  aclk,
  input  logic                                                  areset,
  input  logic [REQUESTERS-1:0]                                 req_valid,
  input  logic [REQUESTERS*COUNTER_WIDTH-1:0]                   req_period,
  output logic [REQUESTERS-1:0]                                 req_ready,
  output logic [REQUESTERS-1:0]                                 done,
  output logic                                                  busy,
  output logic [((REQUESTERS > 1) ? $clog2(REQUESTERS) : 1)-1:0] owner,
  output logic                                                  tx_tvalid,
  output logic [TDATA_BYTES*8-1:0]                              tx_tdata,
  input  logic                                                  tx_tready,
  input  logic                                                  rx_tvalid,
  output logic                                                  rx_tready
`ifdef LOGIC_AXI4_STREAM_TIMER_SCHEDULER_WATCHDOG_EN
  ,
  output logic                                                  timeout
`endif
);

  localparam int OW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

  generate
    if (REQUESTERS < 1) begin : g_chk_requesters
      $error("REQUESTERS must be at least 1");
    end
    if (COUNTER_WIDTH > TDATA_BYTES * 8) begin : g_chk_width
      $error("COUNTER_WIDTH must not exceed TDATA_BYTES*8");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONFIG = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [OW-1:0]            r_ptr;
  logic [OW-1:0]            r_owner;
  logic [COUNTER_WIDTH-1:0] r_period;

  logic                     w_grant_found;
  logic [OW-1:0]            w_grant_idx;
  logic [OW:0]              w_cand;
  logic [COUNTER_WIDTH-1:0] w_grant_period;
  logic                     w_accept;
  logic                     w_wdog_hit;

  // Round-robin search: first asserted request at or after the pointer.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    w_cand        = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      w_cand = {1'b0, r_ptr} + (OW+1)'(i);
      if (w_cand >= (OW+1)'(REQUESTERS)) begin
        w_cand = w_cand - (OW+1)'(REQUESTERS);
      end
      if (!w_grant_found && req_valid[w_cand[OW-1:0]]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = w_cand[OW-1:0];
      end
    end
  end

  assign w_grant_period = req_period[w_grant_idx*COUNTER_WIDTH +: COUNTER_WIDTH];
  assign w_accept       = (r_state == S_IDLE) && w_grant_found;

  // req_ready is combinational, so it is masked by areset to keep it low while in reset.
  always_comb begin
    req_ready = '0;
    if ((r_state == S_IDLE) && w_grant_found && !areset) begin
      req_ready[w_grant_idx] = 1'b1;
    end
  end

  always_comb begin
    done = '0;
    if (r_state == S_DONE) begin
      done[r_owner] = 1'b1;
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign owner     = r_owner;
  assign tx_tvalid = (r_state == S_CONFIG);
  assign rx_tready = (r_state == S_WAIT);

  always_comb begin
    tx_tdata                      = '0;
    tx_tdata[COUNTER_WIDTH-1:0]   = r_period;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = (w_grant_period == '0) ? S_DONE : S_CONFIG;
        end
      end
      S_CONFIG: begin
        if (tx_tready) begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rx_tvalid || w_wdog_hit) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_ptr    <= '0;
      r_owner  <= '0;
      r_period <= '0;
    end else begin
      if (w_accept) begin
        r_owner  <= w_grant_idx;
        r_period <= w_grant_period;
      end
      if (r_state == S_DONE) begin
        if (r_owner == OW'(REQUESTERS - 1)) begin
          r_ptr <= '0;
        end else begin
          r_ptr <= r_owner + 1'b1;
        end
      end
    end
  end

`ifdef LOGIC_AXI4_STREAM_TIMER_SCHEDULER_WATCHDOG_EN
  logic [COUNTER_WIDTH:0]   r_wdog_cnt;
  logic [COUNTER_WIDTH+1:0] w_wdog_limit;
  logic [COUNTER_WIDTH+1:0] w_wdog_next;
  logic                     r_timeout;

  // The count after this WAIT cycle; hitting the limit ends WAIT at this edge.
  assign w_wdog_limit = {2'b00, r_period} + (COUNTER_WIDTH+2)'(WATCHDOG_MARGIN);
  assign w_wdog_next  = {1'b0, r_wdog_cnt} + 1'b1;
  assign w_wdog_hit   = (r_state == S_WAIT) && (w_wdog_next == w_wdog_limit);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_wdog_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_wdog_cnt <= (r_state == S_WAIT) ? w_wdog_next[COUNTER_WIDTH:0] : '0;
      r_timeout  <= w_wdog_hit && !rx_tvalid;
    end
  end

  assign timeout = r_timeout;
`else
  assign w_wdog_hit = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_logic_axi4_stream_timer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_axi4_stream_timer_scheduler
// Purpose  : Directed self-checking bench for the timer scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_logic_axi4_stream_timer_scheduler;

  logic        aclk;
  logic        areset;
  logic [3:0]  req_valid;
  logic [63:0] req_period;
  logic [3:0]  req_ready;
  logic [3:0]  done;
  logic        busy;
  logic [1:0]  owner;
  logic        tx_tvalid;
  logic [31:0] tx_tdata;
  logic        tx_tready;
  logic        rx_tvalid;
  logic        rx_tready;
`ifdef LOGIC_AXI4_STREAM_TIMER_SCHEDULER_WATCHDOG_EN
  logic        timeout;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic_axi4_stream_timer_scheduler #(
    .REQUESTERS    (4),
    .COUNTER_WIDTH (16),
    .TDATA_BYTES   (4)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .req_valid  (req_valid),
    .req_period (req_period),
    .req_ready  (req_ready),
    .done       (done),
    .busy       (busy),
    .owner      (owner),
    .tx_tvalid  (tx_tvalid),
    .tx_tdata   (tx_tdata),
    .tx_tready  (tx_tready),
    .rx_tvalid  (rx_tvalid),
    .rx_tready  (rx_tready)
`ifdef LOGIC_AXI4_STREAM_TIMER_SCHEDULER_WATCHDOG_EN
    ,
    .timeout    (timeout)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_period(input int idx, input logic [15:0] val);
    req_period[idx*16 +: 16] = val;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_time: simulation did not complete, got timeout expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    areset     = 1'b1;
    req_valid  = '0;
    req_period = '0;
    tx_tready  = 1'b0;
    rx_tvalid  = 1'b0;
    #1;
    check_val("rst_busy",      busy,      0);
    check_val("rst_req_ready", req_ready, 0);
    check_val("rst_done",      done,      0);
    check_val("rst_tvalid",    tx_tvalid, 0);
    check_val("rst_tdata",     tx_tdata,  0);
    check_val("rst_rx_tready", rx_tready, 0);
    check_val("rst_owner",     owner,     0);
`ifdef LOGIC_AXI4_STREAM_TIMER_SCHEDULER_WATCHDOG_EN
    check_val("rst_timeout",   timeout,   0);
`endif
    req_valid = 4'hF;
    #1 check_val("rst_req_ready_gated", req_ready, 0);
    req_valid = '0;
    step();
    step();
    areset = 1'b0;

    // Single request from client 2, period 10
    set_period(2, 16'd10);
    req_valid = 4'b0100;
    tx_tready = 1'b1;
    #1;
    check_val("t1_req_ready", req_ready, 4'b0100);
    check_val("t1_busy_idle", busy, 0);
    step();
    req_valid = '0;
    #1;
    check_val("t1_tvalid", tx_tvalid, 1);
    check_val("t1_tdata",  tx_tdata, 10);
    check_val("t1_owner",  owner, 2);
    check_val("t1_busy",   busy, 1);
    step();
    #1;
    check_val("t1_rx_tready",  rx_tready, 1);
    check_val("t1_tvalid_low", tx_tvalid, 0);
    repeat (9) step();
    #1 check_val("t1_wait_no_done", done, 0);
    rx_tvalid = 1'b1;
    step();
    rx_tvalid = 1'b0;
    #1 check_val("t1_done", done, 4'b0100);
    step();
    #1;
    check_val("t1_done_clear", done, 0);
    check_val("t1_busy_clear", busy, 0);
    check_val("t1_owner_hold", owner, 2);
    req_valid = 4'b1101;
    #1 check_val("t1_ptr_is_3", req_ready, 4'b1000);
    req_valid = '0;

    // Zero period from client 1 (pointer 3 wraps to 1)
    set_period(1, 16'd0);
    req_valid = 4'b0010;
    #1 check_val("z_req_ready", req_ready, 4'b0010);
    step();
    req_valid = '0;
    #1;
    check_val("z_done",   done, 4'b0010);
    check_val("z_tvalid", tx_tvalid, 0);
    step();
    #1;
    check_val("z_done_clear", done, 0);
    check_val("z_busy",       busy, 0);
    check_val("z_owner",      owner, 1);

    // Backpressure on config, stray expiry beat during CONFIG
    set_period(0, 16'd7);
    req_valid = 4'b0001;
    tx_tready = 1'b0;
    #1 check_val("bp_req_ready", req_ready, 4'b0001);
    step();
    req_valid = '0;
    for (int i = 0; i < 5; i++) begin
      rx_tvalid = (i == 2);
      #1;
      check_val("bp_tvalid", tx_tvalid, 1);
      check_val("bp_tdata",  tx_tdata, 7);
      if (i == 2) check_val("bp_rx_ignored", rx_tready, 0);
      step();
    end
    rx_tvalid = 1'b0;
    tx_tready = 1'b1;
    #1;
    check_val("bp_tvalid_6", tx_tvalid, 1);
    check_val("bp_tdata_6",  tx_tdata, 7);
    step();
    #1 check_val("bp_in_wait", rx_tready, 1);
    rx_tvalid = 1'b1;
    step();
    rx_tvalid = 1'b0;
    #1 check_val("bp_done", done, 4'b0001);
    step();

    // Reset while waiting for expiry (pointer 1 -> grant 2)
    set_period(2, 16'd5);
    req_valid = 4'b0100;
    #1 check_val("rw_req_ready", req_ready, 4'b0100);
    step();
    req_valid = '0;
    step();
    #1 check_val("rw_in_wait", rx_tready, 1);
    #2 areset = 1'b1;
    #1;
    check_val("rw_busy",      busy, 0);
    check_val("rw_rx_tready", rx_tready, 0);
    check_val("rw_tvalid",    tx_tvalid, 0);
    check_val("rw_tdata",     tx_tdata, 0);
    check_val("rw_done",      done, 0);
    check_val("rw_owner",     owner, 0);
    req_valid = 4'b1010;
    #1 check_val("rw_req_ready_rst", req_ready, 0);
    step();
    #1 check_val("rw_done_none", done, 0);
    areset = 1'b0;
    #1 check_val("rw_first_grant", req_ready, 4'b0010);
    req_valid = '0;

    // Contention: all clients requesting, pointer starts at 0
    for (int k = 0; k < 4; k++) set_period(k, 16'd3);
    req_valid = 4'hF;
    for (int n = 0; n < 5; n++) begin
      #1 check_val("cont_req_ready", req_ready, 32'(4'b0001 << (n % 4)));
      step();
      if (n == 4) req_valid = '0;
      #1 check_val("cont_owner", owner, n % 4);
      step();
      rx_tvalid = 1'b1;
      step();
      rx_tvalid = 1'b0;
      #1 check_val("cont_done", done, 32'(4'b0001 << (n % 4)));
      step();
    end

`ifdef LOGIC_AXI4_STREAM_TIMER_SCHEDULER_WATCHDOG_EN
    // Watchdog: period 4 + margin 16 -> DONE after 20 WAIT cycles
    set_period(0, 16'd4);
    req_valid = 4'b0001;
    #1 check_val("wd_req_ready", req_ready, 4'b0001);
    step();
    req_valid = '0;
    step();
    repeat (19) step();
    #1;
    check_val("wd_still_wait", rx_tready, 1);
    check_val("wd_no_timeout", timeout, 0);
    step();
    #1;
    check_val("wd_done",    done, 4'b0001);
    check_val("wd_timeout", timeout, 1);
    step();
    #1;
    check_val("wd_timeout_clear", timeout, 0);
    check_val("wd_busy",          busy, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
